lc3_mem_unit: RTL
=================

LC3_MEM_UNIT -- requirements
Module: lc3_mem_unit

Interface
REQ-001 Parameter WIDTH, default 16, sets the data/address width in bits; legal range 8..32.
REQ-002 Parameter OFF_W, default 9, sets the signed offset width; legal range 1..WIDTH.
REQ-003 Parameter TIMEOUT, default 16, sets the ack-wait limit in cycles; legal range 2..255; used only under the macro in REQ-030.
REQ-004 Clocking and reset shall be: one clock; reset is synchronous and active-high. Ports are clk and reset.
REQ-005 Port list (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  reset  in  1  synchronous active-high reset
  req_valid  in  1  request offered
  req_ready  out  1  unit can accept a request
  req_op  in  2  access type: 00 LD, 01 ST, 10 LDI, 11 STI
  req_base  in  WIDTH  base address
  req_off  in  OFF_W  signed offset
  req_wdata  in  WIDTH  store data
  rsp_valid  out  1  one-cycle completion pulse
  rsp_data  out  WIDTH  load result (equals MDR)
  rsp_n, rsp_z, rsp_p  out  1 each  NZP of rsp_data; valid with rsp_valid
  rsp_err  out  1  access aborted (timeout)
  mar  out  WIDTH  memory address register
  mdr  out  WIDTH  memory data register; also the write data
  mem_re  out  1  read strobe
  mem_we  out  1  write strobe
  mem_rdata  in  WIDTH  read data, valid when mem_ack=1
  mem_ack  in  1  memory completes the current strobe
  busy  out  1  asserted in every state except IDLE

Function
REQ-006 The FSM shall have states IDLE, PTR, RD, WR, RESP.
REQ-007 req_ready shall be 1 only in IDLE; a handshake occurs when req_valid=1 and req_ready=1 on the same edge.
REQ-008 On handshake: mar <= (req_base + sign-extended req_off) mod 2^WIDTH, with no carry out and wrap-around permitted.
REQ-009 On handshake: mdr <= req_wdata for ST and STI; mdr is unchanged for LD and LDI.
REQ-010 Next state after handshake shall be: LD -> RD, ST -> WR, LDI or STI -> PTR.
REQ-011 PTR: mem_re=1. On mem_ack: mar <= mem_rdata, then go to RD for LDI or WR for STI.
REQ-012 RD: mem_re=1. On mem_ack: mdr <= mem_rdata, then go to RESP.
REQ-013 WR: mem_we=1, with mar and mdr held stable. On mem_ack: go to RESP.
REQ-014 While mem_ack=0, the unit shall stay in PTR, RD or WR; mar, mdr and the strobe shall remain stable.
REQ-015 mem_re and mem_we shall never both be 1; both shall be 0 in IDLE and RESP.
REQ-016 mem_ack shall be ignored in IDLE and RESP.
REQ-017 RESP: rsp_valid=1 for exactly one cycle, then go to IDLE; no back-pressure on responses.
REQ-018 rsp_data shall equal mdr. rsp_n = mdr[WIDTH-1]; rsp_z = (mdr==0); rsp_p = neither; exactly one of the three is 1.
REQ-019 For stores, rsp_data and the flags reflect the written data and are informational only.
REQ-020 Latency from handshake edge to rsp_valid, with zero-wait memory (ack in the first strobe cycle): LD/ST = 2 cycles; LDI/STI = 3 cycles. Each wait cycle adds 1.
REQ-021 Back-to-back operation: a new handshake is possible on the cycle after RESP.
REQ-022 req_* inputs shall be sampled only at the handshake; later changes shall have no effect.

Reset
REQ-023 Reset values: state=IDLE, mar=0, mdr=0, rsp_valid=0, rsp_err=0, mem_re=0, mem_we=0, busy=0, req_ready=1.
REQ-024 Reset values of flags: rsp_z=1, rsp_n=0, rsp_p=0 (derived from mdr=0).
REQ-025 Reset asserted mid-access shall abandon the access with no response; strobes are 0 from the cycle after the reset edge.
REQ-026 Reset has priority over a simultaneous handshake or mem_ack.

Configuration
REQ-030 Macro LC3_MEM_TIMEOUT_EN, when defined, enables a wait counter that clears on entry to PTR, RD or WR and increments each cycle without mem_ack.
REQ-031 With LC3_MEM_TIMEOUT_EN defined: after TIMEOUT consecutive strobe cycles without ack, go to RESP with rsp_err=1, mdr unchanged, and strobe dropped. rsp_err clears on leaving RESP.
REQ-032 With LC3_MEM_TIMEOUT_EN undefined: the unit waits indefinitely, rsp_err is tied to 0, and no counter logic is present.

Verification
REQ-040 LD, base=16'h3000, off=9'h1FF, mem[2FFF]=16'h8001, zero-wait -> mar=2FFF; rsp_valid 2 cycles after handshake; rsp_data=8001; n=1.
REQ-041 STI, base=16'h0010, off=4, mem[0014]=16'h4000, wdata=0000, ack delayed 3 cycles per strobe -> write at 4000 with data 0000; rsp_valid at cycle 9; z=1.
REQ-042 LD, base=16'hFFFF, off=2 -> mar=0001 (wrap-around); no error.
REQ-043 Reset asserted in RD with ack withheld -> next cycle: IDLE, mem_re=0, mar=0, no rsp_valid pulse.
REQ-044 With LC3_MEM_TIMEOUT_EN, TIMEOUT=4, ack never given -> rsp_valid with rsp_err=1 on the 5th cycle after entering RD; without the macro -> busy stays 1 indefinitely.
REQ-045 Two LD requests held back-to-back with req_valid=1 -> second handshake on the cycle after the first RESP; a spurious mem_ack in IDLE causes no state change.

Source files
------------

// File: rtl/lc3_mem_unit.sv
// lc3_mem_unit
// Memory-access unit for an LC-3 style datapath. It accepts one request
// (LD, ST, LDI, STI), forms the effective address base + signed offset,
// performs the pointer read for indirect ops, then the data read or write
// through a simple strobe/ack memory port, and finally emits a one-cycle
// response with the NZP flags of the memory data register.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   req_valid / req_ready   request handshake; ready only while idle
//   req_op                  00 LD, 01 ST, 10 LDI, 11 STI
//   req_base, req_off       base address and signed offset
//   req_wdata               store data
//   rsp_valid               one-cycle completion pulse
//   rsp_data, rsp_n/z/p     MDR and its NZP flags
//   rsp_err                 access aborted by the wait-limit
//   mar, mdr                address / data registers (mdr is write data)
//   mem_re, mem_we          read / write strobes
//   mem_rdata, mem_ack      memory read data and completion
//   busy                    high in every state except idle
//
// Build option: define LC3_MEM_TIMEOUT_EN to abort an access after TIMEOUT
// strobe cycles without mem_ack. Without it the unit waits indefinitely.

module lc3_mem_unit #(
  parameter int WIDTH   = 16,
  parameter int OFF_W   = 9,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_base,
  input  logic [OFF_W-1:0] req_off,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_n,
  output logic             rsp_z,
  output logic             rsp_p,
  output logic             rsp_err,
  output logic [WIDTH-1:0] mar,
  output logic [WIDTH-1:0] mdr,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PTR  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic             store_q, store_d;   // op was ST/STI: PTR continues to WR
  logic [WIDTH-1:0] off_ext;
  logic             strobe;
  logic             timeout;

  // Size cast of a signed value sign-extends, and also covers OFF_W == WIDTH.
  assign off_ext = WIDTH'($signed(req_off));
  assign strobe  = (state_q == S_PTR) || (state_q == S_RD) || (state_q == S_WR);

`ifdef LC3_MEM_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  assign timeout = (wait_q == 8'(TIMEOUT - 1));

  // Counts strobe cycles without ack; any state change restarts it, so it
  // is cleared on entry to each of PTR, RD and WR.
  always_comb begin
    wait_d = 8'd0;
    if (strobe && (state_d == state_q)) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Set only on the edge that aborts into RESP; RESP itself computes 0,
  // so the flag drops when RESP is left.
  assign err_d   = strobe && !mem_ack && timeout;
  assign rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign rsp_err    = 1'b0;
  assign unused_cfg = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    store_d = store_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mar_d   = req_base + off_ext;
          store_d = req_op[0];
          if (req_op[0]) begin
            mdr_d = req_wdata;
          end
          if (req_op[1]) begin
            state_d = S_PTR;
          end else if (req_op[0]) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_PTR: begin
        if (mem_ack) begin
          mar_d   = mem_rdata;
          state_d = store_q ? S_WR : S_RD;
        end else if (timeout) begin
          state_d = S_RESP;
        end
      end
      S_RD: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = S_RESP;
        end else if (timeout) begin
          state_d = S_RESP;
        end
      end
      S_WR: begin
        if (mem_ack || timeout) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      store_q <= store_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_re    = (state_q == S_PTR) || (state_q == S_RD);
  assign mem_we    = (state_q == S_WR);
  assign rsp_valid = (state_q == S_RESP);
  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign rsp_data  = mdr_q;
  assign rsp_n     = mdr_q[WIDTH-1];
  assign rsp_z     = (mdr_q == '0);
  assign rsp_p     = !mdr_q[WIDTH-1] && (mdr_q != '0);

endmodule
